// File: rtl/sdram_refresh_sched.sv
// Refresh scheduler: interval ticks, pending-refresh tracking and a req/ack/busy refresh FSM.
// Optional macro REF_POSTPONE_EN: allow up to 7 postponed refreshes instead of a single pending flag.
module sdram_refresh_sched #(
  parameter int unsigned RF_CNT_SIZE  = 16,
  parameter int unsigned DUR_SIZE     = 4,
  parameter int unsigned URGENT_LEVEL = 4
) (
  input  logic                   clk0,
  input  logic                   reset,
  input  logic [RF_CNT_SIZE-1:0] refresh_count,
  input  logic [DUR_SIZE-1:0]    ref_dur,
  input  logic                   rf_restart,
  input  logic                   ref_ack,
  input  logic                   clr_overrun,
  output logic                   ref_req,
  output logic                   ref_busy,
  output logic                   ref_done,
  output logic [2:0]             ref_pending,
  output logic                   ref_urgent,
  output logic                   ref_overrun
);

`ifdef REF_POSTPONE_EN
  localparam logic [2:0]  PMAX    = 3'd7;
  localparam int unsigned URG_THR = URGENT_LEVEL;
`else
  localparam logic [2:0]  PMAX    = 3'd1;
  // A single pending flag is urgent as soon as it is set, whatever URGENT_LEVEL says.
  localparam int unsigned URG_THR = (URGENT_LEVEL > 0) ? 1 : 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, RUN} state_t;

  state_t                 state, state_nxt;
  logic [RF_CNT_SIZE-1:0] cnt, cnt_nxt;
  logic [DUR_SIZE-1:0]    dur_cnt, dur_nxt;
  logic [2:0]             pending, pending_nxt;
  logic                   overrun, overrun_nxt;
  logic                   done_q, done_nxt;
  logic                   tick, grant;

  // Interval counter; a restart wins over a tick in the same cycle.
  always_comb begin
    tick    = (refresh_count != '0) && !rf_restart &&
              (cnt >= (refresh_count - RF_CNT_SIZE'(1)));
    cnt_nxt = cnt + RF_CNT_SIZE'(1);
    if (rf_restart || tick || (refresh_count == '0))
      cnt_nxt = '0;
  end

  assign grant = (state == REQ) && ref_ack;

  always_comb begin
    pending_nxt = pending;
    overrun_nxt = overrun;
    if (clr_overrun)
      overrun_nxt = 1'b0;
    if (tick && !grant) begin
      if (pending == PMAX)
        overrun_nxt = 1'b1;
      else
        pending_nxt = pending + 3'd1;
    end else if (grant && !tick) begin
      pending_nxt = pending - 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    dur_nxt   = dur_cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (pending != '0) state_nxt = REQ;
      REQ: begin
        if (ref_ack) begin
          state_nxt = RUN;
          dur_nxt   = ref_dur;
        end
      end
      RUN: begin
        if (dur_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          dur_nxt = dur_cnt - DUR_SIZE'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dur_cnt <= '0;
      pending <= '0;
      overrun <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dur_cnt <= dur_nxt;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      done_q  <= done_nxt;
    end
  end

  assign ref_req     = (state == REQ);
  assign ref_busy    = (state == RUN);
  assign ref_done    = done_q;
  assign ref_pending = pending;
  assign ref_urgent  = (32'(pending) >= URG_THR);
  assign ref_overrun = overrun;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed self-checking bench for sdram_refresh_sched (default build or REF_POSTPONE_EN).
module tb_sdram_refresh_sched;

  logic        clk0 = 1'b0;
  logic        reset;
  logic [15:0] refresh_count;
  logic [3:0]  ref_dur;
  logic        rf_restart, ref_ack, clr_overrun;
  logic        ref_req, ref_busy, ref_done, ref_urgent, ref_overrun;
  logic [2:0]  ref_pending;

  int n_run  = 0;
  int n_fail = 0;

`ifdef REF_POSTPONE_EN
  localparam int PMAX_EXP = 7;
`else
  localparam int PMAX_EXP = 1;
`endif

  sdram_refresh_sched #(.RF_CNT_SIZE(16), .DUR_SIZE(4), .URGENT_LEVEL(4)) dut (
    .clk0(clk0), .reset(reset), .refresh_count(refresh_count), .ref_dur(ref_dur),
    .rf_restart(rf_restart), .ref_ack(ref_ack), .clr_overrun(clr_overrun),
    .ref_req(ref_req), .ref_busy(ref_busy), .ref_done(ref_done),
    .ref_pending(ref_pending), .ref_urgent(ref_urgent), .ref_overrun(ref_overrun)
  );

  always #5 clk0 = ~clk0;

  task automatic step(input int n);
    repeat (n) @(posedge clk0);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset just released.
  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    refresh_count = 16'd10; ref_dur = 4'd3; rf_restart = 0; ref_ack = 0; clr_overrun = 0;
    reset = 1'b0;
    step(2);
    n_run++; if (ref_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", ref_req); end
    n_run++; if (ref_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ref_busy); end
    n_run++; if (ref_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ref_done); end
    n_run++; if (ref_pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", ref_pending); end
    n_run++; if (ref_urgent !== 1'b0) begin n_fail++; $display("FAIL reset_urgent: got %b want 0", ref_urgent); end
    n_run++; if (ref_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ref_overrun); end
  endtask

  task automatic test_periodic();
    refresh_count = 16'd10; ref_dur = 4'd3; ref_ack = 1'b1;
    do_reset();
    step(9);
    for (int r = 0; r < 3; r++) begin
      n_run++; if (ref_req !== 1'b0 || ref_pending !== 3'd0) begin n_fail++;
        $display("FAIL per%0d_pre: req=%b pending=%0d want 0/0", r, ref_req, ref_pending); end
      step(1);
      n_run++; if (ref_pending !== 3'd1 || ref_req !== 1'b0) begin n_fail++;
        $display("FAIL per%0d_tick: pending=%0d req=%b want 1/0", r, ref_pending, ref_req); end
      step(1);
      n_run++; if (ref_req !== 1'b1) begin n_fail++; $display("FAIL per%0d_req: got %b want 1", r, ref_req); end
      step(1);
      n_run++; if (ref_req !== 1'b0 || ref_busy !== 1'b1 || ref_pending !== 3'd0) begin n_fail++;
        $display("FAIL per%0d_ack: req=%b busy=%b pending=%0d want 0/1/0", r, ref_req, ref_busy, ref_pending); end
      ref_dur = 4'd9;
      step(3);
      n_run++; if (ref_busy !== 1'b1 || ref_done !== 1'b0) begin n_fail++;
        $display("FAIL per%0d_busy_last: busy=%b done=%b want 1/0", r, ref_busy, ref_done); end
      step(1);
      n_run++; if (ref_busy !== 1'b0 || ref_done !== 1'b1) begin n_fail++;
        $display("FAIL per%0d_done: busy=%b done=%b want 0/1", r, ref_busy, ref_done); end
      step(1);
      ref_dur = 4'd3;
      n_run++; if (ref_done !== 1'b0) begin n_fail++; $display("FAIL per%0d_done_pulse: got %b want 0", r, ref_done); end
      step(2);
    end
    n_run++; if (ref_overrun !== 1'b0) begin n_fail++; $display("FAIL per_overrun: got %b want 0", ref_overrun); end
  endtask

  task automatic test_disabled();
    int bad;
    refresh_count = 16'd0; ref_dur = 4'd0; ref_ack = 1'b1;
    do_reset();
    bad = 0;
    repeat (100) begin
      step(1);
      if (ref_req || ref_pending != 3'd0) bad++;
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL dis_quiet: got %0d active cycles want 0", bad); end
    refresh_count = 16'd5;
    step(5);
    n_run++; if (ref_pending !== 3'd1 || ref_req !== 1'b0) begin n_fail++;
      $display("FAIL dis_first_tick: pending=%0d req=%b want 1/0", ref_pending, ref_req); end
    step(1);
    n_run++; if (ref_req !== 1'b1) begin n_fail++; $display("FAIL dis_first_req: got %b want 1", ref_req); end
  endtask

  task automatic test_saturation();
    int ndone;
    refresh_count = 16'd4; ref_dur = 4'd0; ref_ack = 1'b0; clr_overrun = 1'b0;
    do_reset();
    step(4);
    n_run++; if (ref_pending !== 3'd1 || ref_overrun !== 1'b0) begin n_fail++;
      $display("FAIL sat_t1: pending=%0d overrun=%b want 1/0", ref_pending, ref_overrun); end
`ifdef REF_POSTPONE_EN
    n_run++; if (ref_urgent !== 1'b0) begin n_fail++; $display("FAIL sat_urg1: got %b want 0", ref_urgent); end
    step(11);
    n_run++; if (ref_pending !== 3'd3 || ref_urgent !== 1'b0) begin n_fail++;
      $display("FAIL sat_p3: pending=%0d urgent=%b want 3/0", ref_pending, ref_urgent); end
    step(1);
    n_run++; if (ref_pending !== 3'd4 || ref_urgent !== 1'b1) begin n_fail++;
      $display("FAIL sat_p4: pending=%0d urgent=%b want 4/1", ref_pending, ref_urgent); end
    step(12);
    n_run++; if (ref_pending !== 3'd7 || ref_overrun !== 1'b0) begin n_fail++;
      $display("FAIL sat_p7: pending=%0d overrun=%b want 7/0", ref_pending, ref_overrun); end
    step(4);
    n_run++; if (ref_pending !== 3'd7 || ref_overrun !== 1'b1) begin n_fail++;
      $display("FAIL sat_t8: pending=%0d overrun=%b want 7/1", ref_pending, ref_overrun); end
`else
    n_run++; if (ref_urgent !== 1'b1) begin n_fail++; $display("FAIL sat_urg1: got %b want 1", ref_urgent); end
    step(4);
    n_run++; if (ref_pending !== 3'd1 || ref_overrun !== 1'b1) begin n_fail++;
      $display("FAIL sat_t2: pending=%0d overrun=%b want 1/1", ref_pending, ref_overrun); end
    step(24);
`endif
    step(8);
    n_run++; if (ref_req !== 1'b1) begin n_fail++; $display("FAIL sat_stall_req: got %b want 1", ref_req); end
    clr_overrun = 1'b1;
    step(1);
    n_run++; if (ref_overrun !== 1'b0) begin n_fail++; $display("FAIL sat_clr: got %b want 0", ref_overrun); end
    step(3);
    n_run++; if (ref_overrun !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins: got %b want 1", ref_overrun); end
    clr_overrun = 1'b0;
    refresh_count = 16'd0;
    ref_ack = 1'b1;
    ndone = 0;
    repeat (40) begin
      step(1);
      if (ref_done) ndone++;
    end
    n_run++; if (ndone !== PMAX_EXP) begin n_fail++; $display("FAIL sat_drain: got %0d done want %0d", ndone, PMAX_EXP); end
    n_run++; if (ref_pending !== 3'd0 || ref_overrun !== 1'b1) begin n_fail++;
      $display("FAIL sat_after: pending=%0d overrun=%b want 0/1", ref_pending, ref_overrun); end
  endtask

  task automatic test_restart();
    refresh_count = 16'd10; ref_dur = 4'd0; ref_ack = 1'b1; rf_restart = 1'b0;
    do_reset();
    step(8);
    rf_restart = 1'b1;
    step(1);
    rf_restart = 1'b0;
    step(9);
    n_run++; if (ref_pending !== 3'd0) begin n_fail++; $display("FAIL rst_before: got %0d want 0", ref_pending); end
    step(1);
    n_run++; if (ref_pending !== 3'd1) begin n_fail++; $display("FAIL rst_tick: got %0d want 1", ref_pending); end
    step(9);
    n_run++; if (ref_pending !== 3'd0 || ref_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_idle: pending=%0d req=%b want 0/0", ref_pending, ref_req); end
    rf_restart = 1'b1;
    step(1);
    rf_restart = 1'b0;
    n_run++; if (ref_pending !== 3'd0) begin n_fail++; $display("FAIL rst_suppress: got %0d want 0", ref_pending); end
    step(1);
    n_run++; if (ref_req !== 1'b0) begin n_fail++; $display("FAIL rst_suppress_req: got %b want 0", ref_req); end
    step(8);
    n_run++; if (ref_pending !== 3'd0) begin n_fail++; $display("FAIL rst_before2: got %0d want 0", ref_pending); end
    step(1);
    n_run++; if (ref_pending !== 3'd1) begin n_fail++; $display("FAIL rst_tick2: got %0d want 1", ref_pending); end
  endtask

  task automatic test_reset_midrun();
    int ndone;
    refresh_count = 16'd10; ref_dur = 4'd15; ref_ack = 1'b1;
    do_reset();
    step(14);
    n_run++; if (ref_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", ref_busy); end
    #3 reset = 1'b0;
    #1;
    n_run++; if (ref_busy !== 1'b0 || ref_req !== 1'b0 || ref_pending !== 3'd0 || ref_done !== 1'b0) begin n_fail++;
      $display("FAIL mid_abort: busy=%b req=%b pending=%0d done=%b want 0/0/0/0", ref_busy, ref_req, ref_pending, ref_done); end
    step(1);
    reset = 1'b1;
    ndone = 0;
    repeat (9) begin
      step(1);
      if (ref_done) ndone++;
    end
    n_run++; if (ref_pending !== 3'd0) begin n_fail++; $display("FAIL mid_before: got %0d want 0", ref_pending); end
    step(1);
    if (ref_done) ndone++;
    n_run++; if (ref_pending !== 3'd1) begin n_fail++; $display("FAIL mid_tick: got %0d want 1", ref_pending); end
    n_run++; if (ndone !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_disabled();
    test_saturation();
    test_restart();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
